// File: rtl/vend_controller.sv
// Vending machine controller: coin credit, item selection, timed dispense, change return.
// Optional inactivity refund is compiled in with macro VEND_TIMEOUT_EN.
module vend_controller #(
  parameter logic [7:0]  PRICE0         = 8'd10,
  parameter logic [7:0]  PRICE1         = 8'd15,
  parameter logic [7:0]  PRICE2         = 8'd20,
  parameter logic [7:0]  PRICE3         = 8'd25,
  parameter logic [7:0]  DISPENSE_TIME  = 8'd50,
  parameter logic [7:0]  CREDIT_MAX     = 8'd200,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [7:0] coin_value,
  input  logic       select_valid,
  input  logic [1:0] select_item,
  input  logic       cancel,
  input  logic       waited,
  output logic       wait_req,
  output logic [7:0] k_wait,
  output logic       dispense,
  output logic [1:0] dispense_item,
  output logic       change_valid,
  output logic [7:0] change_amount,
  output logic [7:0] credit,
  output logic       coin_reject,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] credit_q;
  logic [7:0] change_amount_q;
  logic [1:0] item_q;
  logic       wait_req_q;
  logic       dispense_q;
  logic       change_valid_q;
  logic       coin_reject_q;
  logic       busy_q;

  logic [8:0] coin_sum;
  logic       coin_fits;
  logic       tmo_fire;

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = PRICE0;
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      default: price_of = PRICE3;
    endcase
  endfunction

  // 9-bit sum so an overflowing coin is still seen as over the limit
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_fits = (coin_sum <= {1'b0, CREDIT_MAX});

`ifdef VEND_TIMEOUT_EN
  logic [15:0] idle_cnt_q;

  assign tmo_fire = (state_q == IDLE) && (credit_q != 8'd0) && (idle_cnt_q == TIMEOUT_CYCLES);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else if (state_q != IDLE || credit_q == 8'd0 || cancel || select_valid || tmo_fire ||
                 (coin_valid && coin_fits)) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      change_amount_q <= '0;
      item_q          <= '0;
      wait_req_q      <= 1'b0;
      dispense_q      <= 1'b0;
      change_valid_q  <= 1'b0;
      coin_reject_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // cancel (or timeout) dominates; a coin in the same cycle is bounced
          if (cancel || tmo_fire) begin
            coin_reject_q <= coin_valid;
            if (credit_q != 8'd0) begin
              change_amount_q <= credit_q;
              credit_q        <= '0;
              change_valid_q  <= 1'b1;
              busy_q          <= 1'b1;
              state_q         <= CHANGE;
            end
          end else if (coin_valid) begin
            if (coin_fits) credit_q <= coin_sum[7:0];
            else           coin_reject_q <= 1'b1;
          end else if (select_valid && (credit_q >= price_of(select_item))) begin
            item_q     <= select_item;
            wait_req_q <= 1'b1;
            dispense_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= DISPENSE;
          end
        end
        DISPENSE: begin
          coin_reject_q <= coin_valid;
          if (waited) begin
            change_amount_q <= credit_q - price_of(item_q);
            credit_q        <= '0;
            wait_req_q      <= 1'b0;
            dispense_q      <= 1'b0;
            change_valid_q  <= 1'b1;
            state_q         <= CHANGE;
          end
        end
        CHANGE: begin
          coin_reject_q <= coin_valid;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: begin
          wait_req_q <= 1'b0;
          dispense_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign wait_req      = wait_req_q;
  assign k_wait        = DISPENSE_TIME;
  assign dispense      = dispense_q;
  assign dispense_item = item_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign credit        = credit_q;
  assign coin_reject   = coin_reject_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios plus random traffic against a behavioural model.
module tb_vend_controller;

  localparam int DT   = 50;
  localparam int CMAX = 200;
  localparam int TMO  = 20;

  int price [4] = '{10, 15, 20, 25};
  int coins [6] = '{1, 5, 10, 25, 50, 100};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_value = '0;
  logic       select_valid = 1'b0;
  logic [1:0] select_item = '0;
  logic       cancel = 1'b0;
  logic       waited;
  logic       wait_req;
  logic [7:0] k_wait;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [7:0] change_amount;
  logic [7:0] credit;
  logic       coin_reject;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;
  int tcnt;

  // behavioural model of the machine as seen from outside
  int m_credit, m_item, m_change, m_tmo;
  bit m_vending, m_chg, m_rej;

  vend_controller #(.TIMEOUT_CYCLES(16'd20)) dut (
    .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .select_valid(select_valid), .select_item(select_item), .cancel(cancel), .waited(waited),
    .wait_req(wait_req), .k_wait(k_wait), .dispense(dispense), .dispense_item(dispense_item),
    .change_valid(change_valid), .change_amount(change_amount), .credit(credit),
    .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clock = ~clock;

  // downstream hold timer stub: counts cycles of wait_req, done once k_wait reached
  always @(posedge clock or posedge reset) begin
    if (reset)          tcnt <= 0;
    else if (!wait_req) tcnt <= 0;
    else                tcnt <= tcnt + 1;
  end
  assign waited = wait_req && (tcnt >= DT);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_item = 0; m_change = 0; m_tmo = 0;
    m_vending = 0; m_chg = 0; m_rej = 0;
  endtask

  task automatic check_all();
    chk("credit",    credit,        m_credit);
    chk("dispense",  dispense,      m_vending);
    chk("wait_req",  wait_req,      m_vending);
    chk("busy",      busy,          m_vending | m_chg);
    chk("chg_valid", change_valid,  m_chg);
    chk("chg_amt",   change_amount, m_change);
    chk("item",      dispense_item, m_item);
    chk("reject",    coin_reject,   m_rej);
    chk("k_wait",    k_wait,        DT);
  endtask

  task automatic model_next(input bit cv, input int val, input bit s, input int si, input bit x);
    bit fire, in_idle, fits;
    int oc;
    oc      = m_credit;
    in_idle = !m_vending && !m_chg;
    fits    = (oc + val <= CMAX);
    fire    = 1'b0;
`ifdef VEND_TIMEOUT_EN
    fire = in_idle && (oc > 0) && (m_tmo == TMO);
`endif
    m_rej = 1'b0;
    if (m_vending) begin
      m_rej = cv;
      if (waited) begin
        m_change = oc - price[m_item];
        m_credit = 0; m_vending = 0; m_chg = 1;
      end
    end else if (m_chg) begin
      m_rej = cv;
      m_chg = 0;
    end else if (x || fire) begin
      m_rej = cv;
      if (oc > 0) begin m_change = oc; m_credit = 0; m_chg = 1; end
    end else if (cv) begin
      if (fits) m_credit = oc + val;
      else      m_rej = 1'b1;
    end else if (s && oc >= price[si]) begin
      m_item = si; m_vending = 1;
    end
    if (!in_idle)                          m_tmo = 0;
    else if (x || fire || s || (cv && fits)) m_tmo = 0;
    else if (oc > 0)                       m_tmo = m_tmo + 1;
    else                                   m_tmo = 0;
  endtask

  task automatic step(input bit cv, input int val, input bit s, input int si, input bit x);
    @(negedge clock);
    coin_valid   = cv;
    coin_value   = val[7:0];
    select_valid = s;
    select_item  = si[1:0];
    cancel       = x;
    model_next(cv, val, s, si, x);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // run idle cycles until change_valid shows, bounded
  task automatic wait_change(output int ndisp, output bit waited_before);
    bit seen;
    ndisp = 0; waited_before = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (dispense) ndisp++;
      waited_before = waited;
      step(0, 0, 0, 0, 0);
      seen = change_valid;
    end
    chk("chg_seen", seen, 1);
  endtask

  int  ndisp;
  bit  wb;
  bit  r_cv, r_s, r_x;

  initial begin
    model_reset();
    #3;
    check_all();
    @(negedge clock);
    reset = 1'b0;

    // coins 10,5 then item 1: 51 dispense cycles, zero change
    step(1, 10, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("sel1_disp", dispense, 1);
    wait_change(ndisp, wb);
    chk("disp_len", ndisp, 51);
    chk("zero_chg", change_amount, 0);
    chk("zero_cred", credit, 0);

    // credit 30, item 3: change 5 one cycle after waited
    idle(1);
    step(1, 25, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    wait_change(ndisp, wb);
    chk("waited_prev", wb, 1);
    chk("chg5", change_amount, 5);

    // credit 195, over-limit coin, then cancel
    idle(1);
    step(1, 100, 0, 0, 0);
    step(1, 95, 0, 0, 0);
    step(1, 10, 0, 0, 0);
    chk("ovr_rej", coin_reject, 1);
    chk("ovr_cred", credit, 195);
    step(0, 0, 0, 0, 1);
    chk("cancel195", change_amount, 195);
    chk("cancel_cv", change_valid, 1);

    // insufficient select, then coin+select same cycle, coin+cancel
    idle(1);
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("low_sel", dispense, 0);
    step(1, 10, 1, 0, 0);
    chk("cs_cred", credit, 15);
    chk("cs_disp", dispense, 0);
    step(1, 10, 0, 0, 1);
    chk("cc_rej", coin_reject, 1);
    chk("cc_amt", change_amount, 15);
    idle(1);

    // reset in the middle of a dispense
    step(1, 10, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(5);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_wreq", wait_req, 0);
    chk("rst_disp", dispense, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cred", credit, 0);
    check_all();
    @(negedge clock);
    reset = 1'b0;
    idle(3);

    // inactivity refund
    step(1, 10, 0, 0, 0);
`ifdef VEND_TIMEOUT_EN
    idle(TMO);
    chk("tmo_early", change_valid, 0);
    idle(1);
    chk("tmo_cv", change_valid, 1);
    chk("tmo_amt", change_amount, 10);
    idle(1);
`else
    idle(2 * TMO);
    chk("hold_cred", credit, 10);
    step(0, 0, 0, 0, 1);
    idle(1);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r_cv = ($urandom_range(9) < 3);
      r_s  = ($urandom_range(9) < 2);
      r_x  = ($urandom_range(49) == 0);
      step(r_cv, coins[$urandom_range(5)], r_s, $urandom_range(3), r_x);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE0, default 8'd10, meaning price of item 0 in credit units.
REQ-002 SHALL have parameter PRICE1, default 8'd15, meaning price of item 1.
REQ-003 SHALL have parameter PRICE2, default 8'd20, meaning price of item 2.
REQ-004 SHALL have parameter PRICE3, default 8'd25, meaning price of item 3.
REQ-005 SHALL have parameter DISPENSE_TIME, default 8'd50, meaning the hold count driven on k_wait.
REQ-006 SHALL have parameter CREDIT_MAX, default 8'd200, meaning the maximum credit accepted.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 16'd1000, meaning the inactivity refund delay.
REQ-008 SHALL have ports: clock in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-009 SHALL have ports: coin_valid in 1 one-cycle coin strobe; coin_value in 8 coin credit units.
REQ-010 SHALL have ports: select_valid in 1 one-cycle selection strobe; select_item in 2 item index; cancel in 1 one-cycle refund request.
REQ-011 SHALL have port waited in 1, driven by the downstream hold-timer done flag.
REQ-012 SHALL have ports: wait_req out 1 hold-timer enable; k_wait out 8 hold count.
REQ-013 SHALL have ports: dispense out 1 motor enable; dispense_item out 2 latched item.
REQ-014 SHALL have ports: change_valid out 1 one-cycle change strobe; change_amount out 8 change value.
REQ-015 SHALL have ports: credit out 8 current credit; coin_reject out 1 one-cycle reject strobe; busy out 1 high outside IDLE.

Function
REQ-016 SHALL implement states IDLE, DISPENSE and CHANGE.
REQ-017 IDLE SHALL add coin_value to credit on coin_valid when credit+coin_value <= CREDIT_MAX, using a 9-bit sum.
REQ-018 An over-limit coin SHALL leave credit unchanged and pulse coin_reject for one cycle.
REQ-019 In IDLE, select_valid with credit >= price[select_item] SHALL latch dispense_item and move to DISPENSE on the next edge.
REQ-020 A selection with insufficient credit SHALL be ignored, with no state or credit change.
REQ-021 In IDLE, cancel with credit > 0 SHALL move to CHANGE with a refund equal to the full credit; cancel with credit = 0 SHALL be ignored.
REQ-022 Same-cycle priority SHALL be cancel > coin > select; a coin arriving alongside cancel SHALL be rejected (coin_reject), and a select arriving alongside a coin SHALL be ignored.
REQ-023 DISPENSE SHALL drive wait_req=1, dispense=1 and k_wait=DISPENSE_TIME.
REQ-024 DISPENSE SHALL leave on the first edge where waited=1, giving DISPENSE_TIME+1 cycles with a compliant timer.
REQ-025 wait_req SHALL be 0 in IDLE and CHANGE so the downstream timer is cleared before each dispense.
REQ-026 On the DISPENSE exit, change_amount SHALL be set to credit-price and credit SHALL be cleared.
REQ-027 CHANGE SHALL last exactly one cycle with change_valid=1 and return to IDLE.
REQ-028 change_valid SHALL pulse even when change_amount is 0 after a dispense.
REQ-029 In DISPENSE and CHANGE, coin_valid SHALL pulse coin_reject, and select_valid and cancel SHALL be ignored.
REQ-030 busy SHALL be 1 in DISPENSE and CHANGE.
REQ-031 k_wait SHALL be held at DISPENSE_TIME in all states.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE and clear credit, dispense_item, change_amount and the timeout counter.
REQ-033 Asserting reset SHALL immediately clear wait_req, dispense, change_valid, coin_reject and busy.
REQ-034 A reset during DISPENSE SHALL abort the vend with no change pulse; the credit is lost by design.

Configuration
REQ-035 With macro VEND_TIMEOUT_EN defined, a 16-bit counter SHALL count IDLE cycles while credit > 0, clearing on every accepted coin, select attempt or cancel.
REQ-036 With VEND_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES SHALL act as cancel, moving to CHANGE with the full credit.
REQ-037 Without VEND_TIMEOUT_EN, the counter SHALL not exist and credit SHALL be held indefinitely.

Verification
REQ-038 Coins 10,5 then select item 1 (price 15) SHALL give dispense high for 51 cycles, then change_valid with change_amount=0 and credit=0.
REQ-039 Credit 30, select item 3 (price 25) SHALL give change_amount=5 one cycle after waited.
REQ-040 Credit 195 plus coin 10 SHALL pulse coin_reject and keep credit at 195; cancel SHALL then give change_amount=195.
REQ-041 Credit 5, select item 0 SHALL ignore the selection; same-cycle coin+select SHALL credit the coin only.
REQ-042 Reset mid-DISPENSE SHALL drop wait_req, dispense and busy immediately, with credit=0 and no change_valid.
REQ-043 With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=20, credit 10 idle 20 cycles SHALL auto-refund change_amount=10; without the macro, credit 10 SHALL persist.
